frame_align_ctrl: RTL and testbench

Read-side sequencer and frame aligner for the 40-bit variable-read word buffer in the ETROC2 readout path. It drives the buffer's write/read strobes and per-read length. In the buffer output it hunts for the frame sync field, slipping one bit per failed read until the stream is locked. Once locked, it forwards aligned 40-bit frames downstream with ready/valid flow control. It sits between the ETROC2 deserializer output and the event builder, alongside one buffer instance (OUTPUTWIDTH = FRAMEWIDTH) in the same wrapper.

---
 rtl/frame_align_pkg.sv | 20 ++
 rtl/frame_align_ctrl.sv | 158 +++++++++++++++
 tb/tb_frame_align_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_align_pkg.sv
// Shared constants for the ETROC2 read-side frame aligner: default frame
// geometry, sync field definition and the legacy 2-bit FSM encoding.
package frame_align_pkg;

  localparam int          DEF_FRAMEWIDTH    = 40;
  localparam logic [17:0] DEF_SYNC_PAT      = 18'h03C5C;
  localparam int          DEF_SYNC_LSB      = 22;
  localparam int          DEF_LOCK_THRESH   = 32;
  localparam int          DEF_UNLOCK_THRESH = 4;

  // A slipping read consumes one extra bit to move the frame boundary.
  localparam int          SLIPLEN           = DEF_FRAMEWIDTH + 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_SEARCH  = 2'd0;
  localparam state_t ST_CONFIRM = 2'd1;
  localparam state_t ST_LOCKED  = 2'd2;

endpackage

// File: rtl/frame_align_ctrl.sv
// Read-side sequencer for the variable-read word buffer: hunts for the frame
// sync field one bit slip at a time, then forwards aligned frames.
module frame_align_ctrl
  import frame_align_pkg::*;
#(
  parameter int          FRAMEWIDTH    = DEF_FRAMEWIDTH,
  parameter logic [17:0] SYNC_PAT      = DEF_SYNC_PAT,
  parameter int          SYNC_LSB      = DEF_SYNC_LSB,
  parameter int          LOCK_THRESH   = DEF_LOCK_THRESH,
  parameter int          UNLOCK_THRESH = DEF_UNLOCK_THRESH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  buf_wren,
  output logic                  buf_rden,
  output logic [6:0]            buf_readLength,
  input  logic [FRAMEWIDTH-1:0] buf_dout,
  input  logic [6:0]            buf_bitsCount,
  input  logic                  buf_full,
  output logic [FRAMEWIDTH-1:0] out_frame,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  locked,
  output logic [5:0]            slip_cnt,
  output logic                  overflow,
  output logic                  search_wrap
);

  localparam int            GW        = $clog2(LOCK_THRESH + 1);
  localparam int            BW        = $clog2(UNLOCK_THRESH + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_THRESH - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_THRESH - 1);
  localparam logic [6:0]    LEN_FRAME = 7'(FRAMEWIDTH);
  localparam logic [6:0]    LEN_SLIP  = 7'(FRAMEWIDTH + 1);
  localparam logic [5:0]    SLIP_LAST = 6'(FRAMEWIDTH - 1);

  state_t                  state_q, state_d;
  logic [GW-1:0]           good_cnt_q, good_cnt_d;
  logic [BW-1:0]           bad_cnt_q, bad_cnt_d;
  logic [5:0]              slip_cnt_q, slip_cnt_d;
  logic                    overflow_q, overflow_d;
  logic                    search_wrap_q, search_wrap_d;
  logic [FRAMEWIDTH-1:0]   out_frame_q, out_frame_d;
  logic                    out_valid_q, out_valid_d;

  logic hunting;
  logic match;
  logic rd_ok;
  logic slip;
  logic load;

  // While hunting, a read is only issued when a slip read would also be covered.
  always_comb begin
    hunting  = (state_q != ST_LOCKED);
    match    = (buf_dout[SYNC_LSB +: 18] == SYNC_PAT);
    in_ready = ~buf_full;
    buf_wren = rstn & in_valid & ~buf_full;
    if (hunting) begin
      rd_ok = (buf_bitsCount >= LEN_SLIP);
    end else begin
      rd_ok = (buf_bitsCount >= LEN_FRAME) & (~out_valid_q | out_ready);
    end
    buf_rden       = rstn & rd_ok;
    slip           = buf_rden & hunting & ~match;
    load           = buf_rden & ~hunting;
    buf_readLength = slip ? LEN_SLIP : LEN_FRAME;
  end

  always_comb begin
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;
    bad_cnt_d     = bad_cnt_q;
    slip_cnt_d    = slip_cnt_q;
    search_wrap_d = search_wrap_q;
    overflow_d    = overflow_q | (in_valid & buf_full);

    if (slip) begin
      if (slip_cnt_q == SLIP_LAST) begin
        slip_cnt_d    = '0;
        search_wrap_d = 1'b1;
      end else begin
        slip_cnt_d = slip_cnt_q + 6'd1;
      end
    end

    if (buf_rden) begin
      case (state_q)
        ST_SEARCH: begin
          if (match) begin
            state_d    = ST_CONFIRM;
            good_cnt_d = GW'(1);
          end
        end
        ST_CONFIRM: begin
          if (!match) begin
            state_d    = ST_SEARCH;
            good_cnt_d = '0;
          end else if (good_cnt_q >= GOOD_LAST) begin
            state_d    = ST_LOCKED;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
          end else begin
            good_cnt_d = good_cnt_q + GW'(1);
          end
        end
        ST_LOCKED: begin
          if (match) begin
            bad_cnt_d = '0;
          end else if (bad_cnt_q >= BAD_LAST) begin
            state_d   = ST_SEARCH;
            bad_cnt_d = '0;
          end else begin
            bad_cnt_d = bad_cnt_q + BW'(1);
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  // The output register only moves when downstream is not stalling it.
  always_comb begin
    out_frame_d = load ? buf_dout : out_frame_q;
    out_valid_d = load | (out_valid_q & ~out_ready);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_SEARCH;
      good_cnt_q    <= '0;
      bad_cnt_q     <= '0;
      slip_cnt_q    <= '0;
      overflow_q    <= 1'b0;
      search_wrap_q <= 1'b0;
      out_frame_q   <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      slip_cnt_q    <= slip_cnt_d;
      overflow_q    <= overflow_d;
      search_wrap_q <= search_wrap_d;
      out_frame_q   <= out_frame_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign out_frame   = out_frame_q;
  assign out_valid   = out_valid_q;
  assign locked      = (state_q == ST_LOCKED);
  assign slip_cnt    = slip_cnt_q;
  assign overflow    = overflow_q;
  assign search_wrap = search_wrap_q;

endmodule

// File: tb/tb_frame_align_ctrl.sv
// Bench for frame_align_ctrl: a bit-queue buffer stand-in plus a reference
// aligner modelled as runs of matching/mismatching frames.
module tb_frame_align_ctrl;

  localparam int          FW     = 40;
  localparam int          LSB    = 22;
  localparam logic [17:0] SYNC   = 18'h03C5C;
  localparam int          LOCK   = 32;
  localparam int          UNLOCK = 4;
  localparam int          CAP    = 120;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic          buf_wren;
  logic          buf_rden;
  logic [6:0]    buf_readLength;
  logic [FW-1:0] buf_dout;
  logic [6:0]    buf_bitsCount;
  logic          buf_full;
  logic [FW-1:0] out_frame;
  logic          out_valid;
  logic          out_ready;
  logic          locked;
  logic [5:0]    slip_cnt;
  logic          overflow;
  logic          search_wrap;

  frame_align_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .buf_wren       (buf_wren),
    .buf_rden       (buf_rden),
    .buf_readLength (buf_readLength),
    .buf_dout       (buf_dout),
    .buf_bitsCount  (buf_bitsCount),
    .buf_full       (buf_full),
    .out_frame      (out_frame),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .locked         (locked),
    .slip_cnt       (slip_cnt),
    .overflow       (overflow),
    .search_wrap    (search_wrap)
  );

  always #5 clk = ~clk;

  bit            bq[$];
  logic [FW-1:0] src[$];
  logic [FW-1:0] made[$];
  bit            corrupt[64];
  bit            src_en;
  int            rd_cnt, acc_cnt;
  int            n_vec, n_err;

  logic          act_wr, act_rd, exp_wr, exp_rd, act_in_ready;
  logic [6:0]    act_len, exp_len;
  logic [FW-1:0] rd_frame;

  bit            ref_locked, ref_valid, ref_wrap, ref_ovf;
  int            ref_run, ref_miss, ref_slip;
  logic [FW-1:0] ref_frame = '0;

  task automatic ref_reset();
    ref_locked = 0; ref_valid = 0; ref_wrap = 0; ref_ovf = 0;
    ref_run = 0; ref_miss = 0; ref_slip = 0; ref_frame = '0;
  endtask

  // One clock: present buffer state, sample strobes, then advance buffer and model.
  task automatic cycle();
    bit m;
    logic [FW-1:0] w;
    buf_bitsCount = 7'(bq.size());
    buf_full      = (int'(bq.size()) > CAP - FW);
    for (int i = 0; i < FW; i++) buf_dout[i] = (i < int'(bq.size())) ? bq[i] : 1'b0;
    in_valid = src_en && (src.size() > 0);
    #1;
    m       = (buf_dout[LSB +: 18] == SYNC);
    exp_wr  = rstn && in_valid && !buf_full;
    exp_rd  = rstn && (ref_locked ? (int'(bq.size()) >= FW && (!ref_valid || out_ready))
                                  : (int'(bq.size()) >= FW + 1));
    exp_len = (exp_rd && !ref_locked && !m) ? 7'(frame_align_pkg::SLIPLEN) : 7'(FW);
    act_wr = buf_wren; act_rd = buf_rden; act_len = buf_readLength; act_in_ready = in_ready;
    rd_frame = buf_dout;
    if (out_valid === 1'b1 && out_ready) acc_cnt++;
    @(posedge clk);
    #1;
    if (!rstn) begin
      bq.delete();
      ref_reset();
    end else begin
      if (act_rd === 1'b1) begin
        for (int i = 0; i < int'(act_len) && bq.size() > 0; i++) void'(bq.pop_front());
        rd_cnt++;
        if (ref_locked) begin
          ref_valid = 1; ref_frame = rd_frame;
          if (m) ref_miss = 0;
          else begin
            ref_miss++;
            if (ref_miss == UNLOCK) begin ref_locked = 0; ref_miss = 0; end
          end
        end else begin
          if (out_ready) ref_valid = 0;
          if (m) begin
            ref_run++;
            if (ref_run == LOCK) begin ref_locked = 1; ref_run = 0; ref_miss = 0; end
          end else begin
            ref_run = 0;
            ref_slip = (ref_slip + 1) % FW;
            if (ref_slip == 0) ref_wrap = 1;
          end
        end
      end else if (out_ready) begin
        ref_valid = 0;
      end
      if (in_valid && buf_full) begin
        ref_ovf = 1;
        void'(src.pop_front());
      end else if (act_wr === 1'b1 && src.size() > 0) begin
        w = src.pop_front();
        for (int i = 0; i < FW; i++) bq.push_back(w[i]);
      end
    end
    @(negedge clk);
  endtask

  // Concatenate pad bits and frames into a bit stream, re-chunked as 40-bit writes.
  task automatic build_stream(input int pad, input int nframes, input bit with_sync);
    bit sb[$];
    logic [FW-1:0] f;
    logic [17:0] x;
    made.delete();
    for (int i = 0; i < pad; i++) sb.push_back(1'($urandom));
    for (int n = 0; n < nframes; n++) begin
      f = {8'($urandom), $urandom};
      if (with_sync) begin
        x = 18'($urandom_range(1, 18'h3FFFF));
        f[LSB +: 18] = corrupt[n] ? (SYNC ^ x) : SYNC;
      end
      made.push_back(f);
      for (int i = 0; i < FW; i++) sb.push_back(f[i]);
    end
    while (sb.size() % FW != 0) sb.push_back(1'($urandom));
    for (int w = 0; w < int'(sb.size()) / FW; w++) begin
      for (int i = 0; i < FW; i++) f[i] = sb[w*FW + i];
      src.push_back(f);
    end
  endtask

  task automatic reset_dut();
    src.delete();
    for (int i = 0; i < 64; i++) corrupt[i] = 0;
    src_en = 0; out_ready = 1; rstn = 0;
    cycle();
    rstn = 1; rd_cnt = 0; acc_cnt = 0;
  endtask

  task automatic test_reset();
    src.delete();
    build_stream(0, 1, 1);
    src_en = 1; out_ready = 1; rstn = 0;
    cycle();
    cycle();
    n_vec++; if (act_wr !== 1'b0) begin n_err++; $display("[TB] FAIL rst_wren: got %0b expected 0", act_wr); end
    n_vec++; if (act_rd !== 1'b0) begin n_err++; $display("[TB] FAIL rst_rden: got %0b expected 0", act_rd); end
    n_vec++; if (act_in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rst_in_ready: got %0b expected 1", act_in_ready); end
    n_vec++; if (out_frame !== '0) begin n_err++; $display("[TB] FAIL rst_out_frame: got %0h expected 0", out_frame); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_out_valid: got %0b expected 0", out_valid); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("[TB] FAIL rst_locked: got %0b expected 0", locked); end
    n_vec++; if (slip_cnt !== 6'd0) begin n_err++; $display("[TB] FAIL rst_slip_cnt: got %0d expected 0", slip_cnt); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("[TB] FAIL rst_overflow: got %0b expected 0", overflow); end
    n_vec++; if (search_wrap !== 1'b0) begin n_err++; $display("[TB] FAIL rst_search_wrap: got %0b expected 0", search_wrap); end
    src_en = 0; src.delete(); rstn = 1;
  endtask

  task automatic test_prealigned_lock();
    bit done;
    done = 0;
    reset_dut();
    build_stream(0, 40, 1);
    src_en = 1;
    for (int c = 0; c < 300; c++) begin
      cycle();
      n_vec++; if (act_rd !== exp_rd) begin n_err++; $display("[TB] FAIL pre_rden: got %0b expected %0b", act_rd, exp_rd); end
      n_vec++; if (act_len !== exp_len) begin n_err++; $display("[TB] FAIL pre_len: got %0d expected %0d", act_len, exp_len); end
      n_vec++; if (locked !== ref_locked) begin n_err++; $display("[TB] FAIL pre_locked: got %0b expected %0b", locked, ref_locked); end
      n_vec++; if (slip_cnt !== 6'd0) begin n_err++; $display("[TB] FAIL pre_slip: got %0d expected 0", slip_cnt); end
      n_vec++; if (out_valid !== ref_valid) begin n_err++; $display("[TB] FAIL pre_out_valid: got %0b expected %0b", out_valid, ref_valid); end
      n_vec++; if (out_frame !== ref_frame) begin n_err++; $display("[TB] FAIL pre_out_frame: got %0h expected %0h", out_frame, ref_frame); end
      if (act_rd === 1'b1 && rd_cnt == LOCK - 1) begin
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("[TB] FAIL pre_early_lock: got %0b expected 0", locked); end
      end
      if (act_rd === 1'b1 && rd_cnt == LOCK) begin
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("[TB] FAIL pre_lock_edge: got %0b expected 1", locked); end
      end
      if (src.size() == 0 && act_rd !== 1'b1 && !ref_valid) begin done = 1; break; end
    end
    n_vec++; if (!done) begin n_err++; $display("[TB] FAIL pre_timeout: got running expected drained"); end
    n_vec++; if (acc_cnt !== 40 - LOCK) begin n_err++; $display("[TB] FAIL pre_forwarded: got %0d expected %0d", acc_cnt, 40 - LOCK); end
  endtask

  task automatic test_offset_lock();
    bit done;
    int nslip;
    done = 0; nslip = 0;
    reset_dut();
    build_stream(13, 50, 1);
    src_en = 1;
    for (int c = 0; c < 400; c++) begin
      cycle();
      if (act_rd === 1'b1 && act_len == 7'(FW + 1)) nslip++;
      n_vec++; if (act_len !== exp_len) begin n_err++; $display("[TB] FAIL off_len: got %0d expected %0d", act_len, exp_len); end
      n_vec++; if (slip_cnt !== 6'(ref_slip)) begin n_err++; $display("[TB] FAIL off_slip: got %0d expected %0d", slip_cnt, ref_slip); end
      n_vec++; if (locked !== ref_locked) begin n_err++; $display("[TB] FAIL off_locked: got %0b expected %0b", locked, ref_locked); end
      n_vec++; if (out_frame !== ref_frame) begin n_err++; $display("[TB] FAIL off_out_frame: got %0h expected %0h", out_frame, ref_frame); end
      if (src.size() == 0 && act_rd !== 1'b1 && !ref_valid) begin done = 1; break; end
    end
    n_vec++; if (!done) begin n_err++; $display("[TB] FAIL off_timeout: got running expected drained"); end
    n_vec++; if (nslip !== 13) begin n_err++; $display("[TB] FAIL off_slip_reads: got %0d expected 13", nslip); end
    n_vec++; if (slip_cnt !== 6'd13) begin n_err++; $display("[TB] FAIL off_slip_final: got %0d expected 13", slip_cnt); end
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("[TB] FAIL off_locked_final: got %0b expected 1", locked); end
    n_vec++; if (acc_cnt !== 5) begin n_err++; $display("[TB] FAIL off_forwarded: got %0d expected 5", acc_cnt); end
  endtask

  task automatic test_unlock();
    bit done;
    done = 0;
    reset_dut();
    for (int i = 36; i <= 38; i++) corrupt[i] = 1;
    for (int i = 44; i <= 47; i++) corrupt[i] = 1;
    build_stream(0, 52, 1);
    src_en = 1;
    for (int c = 0; c < 400; c++) begin
      cycle();
      n_vec++; if (locked !== ref_locked) begin n_err++; $display("[TB] FAIL unl_locked: got %0b expected %0b", locked, ref_locked); end
      n_vec++; if (out_frame !== ref_frame) begin n_err++; $display("[TB] FAIL unl_out_frame: got %0h expected %0h", out_frame, ref_frame); end
      if (act_rd === 1'b1 && rd_cnt == 39) begin
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("[TB] FAIL unl_three_bad: got %0b expected 1", locked); end
      end
      if (act_rd === 1'b1 && rd_cnt == 48) begin
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("[TB] FAIL unl_fourth_bad: got %0b expected 0", locked); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL unl_last_valid: got %0b expected 1", out_valid); end
        n_vec++; if (out_frame !== made[47]) begin n_err++; $display("[TB] FAIL unl_last_frame: got %0h expected %0h", out_frame, made[47]); end
      end
      if (src.size() == 0 && act_rd !== 1'b1 && !ref_valid) begin done = 1; break; end
    end
    n_vec++; if (!done) begin n_err++; $display("[TB] FAIL unl_timeout: got running expected drained"); end
    n_vec++; if (acc_cnt !== 16) begin n_err++; $display("[TB] FAIL unl_forwarded: got %0d expected 16", acc_cnt); end
    n_vec++; if (slip_cnt !== 6'd0) begin n_err++; $display("[TB] FAIL unl_slip: got %0d expected 0", slip_cnt); end
  endtask

  task automatic test_backpressure();
    bit done, saw_full;
    logic [FW-1:0] held;
    done = 0; saw_full = 0;
    reset_dut();
    build_stream(0, 60, 1);
    src_en = 1;
    for (int c = 0; c < 300; c++) begin
      cycle();
      n_vec++; if (out_frame !== ref_frame) begin n_err++; $display("[TB] FAIL bp_pre_frame: got %0h expected %0h", out_frame, ref_frame); end
      if (ref_locked && acc_cnt >= 3) begin done = 1; break; end
    end
    n_vec++; if (!done) begin n_err++; $display("[TB] FAIL bp_lock_timeout: got unlocked expected locked"); end
    held = out_frame;
    out_ready = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (act_in_ready === 1'b0) saw_full = 1;
      n_vec++; if (act_rd !== 1'b0) begin n_err++; $display("[TB] FAIL bp_rden: got %0b expected 0", act_rd); end
      n_vec++; if (act_wr !== exp_wr) begin n_err++; $display("[TB] FAIL bp_wren: got %0b expected %0b", act_wr, exp_wr); end
      n_vec++; if (act_in_ready !== !buf_full) begin n_err++; $display("[TB] FAIL bp_in_ready: got %0b expected %0b", act_in_ready, !buf_full); end
      n_vec++; if (out_frame !== held) begin n_err++; $display("[TB] FAIL bp_hold: got %0h expected %0h", out_frame, held); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bp_valid: got %0b expected 1", out_valid); end
      n_vec++; if (overflow !== ref_ovf) begin n_err++; $display("[TB] FAIL bp_overflow: got %0b expected %0b", overflow, ref_ovf); end
    end
    n_vec++; if (!saw_full) begin n_err++; $display("[TB] FAIL bp_full_seen: got 0 expected 1"); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("[TB] FAIL bp_overflow_final: got %0b expected 1", overflow); end
    out_ready = 1;
    done = 0;
    for (int c = 0; c < 300; c++) begin
      cycle();
      n_vec++; if (act_rd !== exp_rd) begin n_err++; $display("[TB] FAIL bp_post_rden: got %0b expected %0b", act_rd, exp_rd); end
      n_vec++; if (out_frame !== ref_frame) begin n_err++; $display("[TB] FAIL bp_post_frame: got %0h expected %0h", out_frame, ref_frame); end
      if (src.size() == 0 && act_rd !== 1'b1 && !ref_valid) begin done = 1; break; end
    end
    n_vec++; if (!done) begin n_err++; $display("[TB] FAIL bp_timeout: got running expected drained"); end
  endtask

  task automatic test_search_wrap();
    bit done;
    int prev;
    done = 0;
    reset_dut();
    build_stream(0, 50, 0);
    src_en = 1;
    for (int c = 0; c < 400; c++) begin
      prev = int'(slip_cnt);
      cycle();
      n_vec++; if (slip_cnt !== 6'(ref_slip)) begin n_err++; $display("[TB] FAIL sw_slip: got %0d expected %0d", slip_cnt, ref_slip); end
      n_vec++; if (search_wrap !== ref_wrap) begin n_err++; $display("[TB] FAIL sw_wrap: got %0b expected %0b", search_wrap, ref_wrap); end
      n_vec++; if (locked !== ref_locked) begin n_err++; $display("[TB] FAIL sw_locked: got %0b expected %0b", locked, ref_locked); end
      if (act_rd === 1'b1 && act_len == 7'(FW + 1) && prev == FW - 1) begin
        n_vec++; if (search_wrap !== 1'b1) begin n_err++; $display("[TB] FAIL sw_wrap_edge: got %0b expected 1", search_wrap); end
      end
      if (src.size() == 0 && act_rd !== 1'b1 && !ref_valid) begin done = 1; break; end
    end
    n_vec++; if (!done) begin n_err++; $display("[TB] FAIL sw_timeout: got running expected drained"); end
    n_vec++; if (search_wrap !== 1'b1) begin n_err++; $display("[TB] FAIL sw_wrap_final: got %0b expected 1", search_wrap); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("[TB] FAIL sw_locked_final: got %0b expected 0", locked); end
  endtask

  task automatic test_reset_midlock();
    bit done;
    done = 0;
    reset_dut();
    build_stream(0, 45, 1);
    src_en = 1;
    for (int c = 0; c < 300; c++) begin
      cycle();
      if (ref_locked && ref_valid) begin done = 1; break; end
    end
    n_vec++; if (!done) begin n_err++; $display("[TB] FAIL mid_lock_timeout: got unlocked expected locked"); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL mid_pre_valid: got %0b expected 1", out_valid); end
    rstn = 0;
    cycle();
    n_vec++; if (act_rd !== 1'b0) begin n_err++; $display("[TB] FAIL mid_rden: got %0b expected 0", act_rd); end
    n_vec++; if (act_wr !== 1'b0) begin n_err++; $display("[TB] FAIL mid_wren: got %0b expected 0", act_wr); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL mid_out_valid: got %0b expected 0", out_valid); end
    n_vec++; if (out_frame !== '0) begin n_err++; $display("[TB] FAIL mid_out_frame: got %0h expected 0", out_frame); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("[TB] FAIL mid_locked: got %0b expected 0", locked); end
    n_vec++; if (slip_cnt !== 6'd0) begin n_err++; $display("[TB] FAIL mid_slip: got %0d expected 0", slip_cnt); end
    rstn = 1;
    src.delete(); rd_cnt = 0; acc_cnt = 0; done = 0;
    build_stream(0, 40, 1);
    for (int c = 0; c < 300; c++) begin
      cycle();
      n_vec++; if (locked !== ref_locked) begin n_err++; $display("[TB] FAIL mid_relock: got %0b expected %0b", locked, ref_locked); end
      n_vec++; if (out_frame !== ref_frame) begin n_err++; $display("[TB] FAIL mid_out_frame_relock: got %0h expected %0h", out_frame, ref_frame); end
      if (act_rd === 1'b1 && rd_cnt == LOCK) begin
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("[TB] FAIL mid_lock_edge: got %0b expected 1", locked); end
      end
      if (src.size() == 0 && act_rd !== 1'b1 && !ref_valid) begin done = 1; break; end
    end
    n_vec++; if (!done) begin n_err++; $display("[TB] FAIL mid_timeout: got running expected drained"); end
    n_vec++; if (acc_cnt !== 40 - LOCK) begin n_err++; $display("[TB] FAIL mid_forwarded: got %0d expected %0d", acc_cnt, 40 - LOCK); end
  endtask

  initial begin
    n_vec = 0; n_err = 0; rd_cnt = 0; acc_cnt = 0;
    src_en = 0; out_ready = 1; rstn = 0;
    ref_reset();
    test_reset();
    test_prealigned_lock();
    test_offset_lock();
    test_unlock();
    test_backpressure();
    test_search_wrap();
    test_reset_midlock();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
